// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared parameters, widths and types for the RAM FIFO controller and its RAM
package ram_fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_AFULL_LVL  = 48;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers carry one extra wrap bit above the RAM address; counts span 0..DEPTH.
  typedef logic [DEF_ADDR_WIDTH:0]   ptr_t;
  typedef logic [DEF_ADDR_WIDTH:0]   cnt_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/ram_fifo_ctrl_wrap_ptr.sv
// rtl/ram_fifo_ctrl_wrap_ptr.sv - free-running wrap-bit pointer with increment and synchronous clear
module wrap_ptr #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  // Natural binary wrap at 2**W keeps the MSB toggling once per lap of the RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= ptr_o + W'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - circular-buffer controller driving a dual-port RAM as a show-ahead FIFO
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AFULL_LVL  = DEF_AFULL_LVL
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  rd_ready_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  almost_full_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LVL);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                full;
  logic                empty;
  logic                hold;
  logic                push;
  logic                pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // A clearing edge swallows both handshakes so no stray RAM write lands.
  assign hold = rst_i || flush_i;
  assign push = wr_valid_i && !full && !hold;
  assign pop  = rd_ready_i && !empty && !hold;

  assign wr_ready_o    = !full;
  assign rd_valid_o    = !empty;
  assign count_o       = wr_ptr - rd_ptr;
  assign almost_full_o = (count_o >= AFULL_CNT);

  assign ram_we_o    = push;
  assign ram_waddr_o = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wdata_o = wr_data_i;
  assign ram_raddr_o = rd_ptr[ADDR_WIDTH-1:0];
  assign rd_data_o   = ram_rdata_i;

  wrap_ptr #(.W(ADDR_WIDTH+1)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  wrap_ptr #(.W(ADDR_WIDTH+1)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a behavioural RAM and queue model
module tb_ram_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [AW:0]   count;
  logic          almost_full;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q [$];
  int            wr_total = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_LVL(AFULL)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .wr_valid_i    (wr_valid),
    .wr_data_i     (wr_data),
    .wr_ready_o    (wr_ready),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data),
    .rd_ready_i    (rd_ready),
    .count_o       (count),
    .almost_full_o (almost_full),
    .ram_we_o      (ram_we),
    .ram_waddr_o   (ram_waddr),
    .ram_wdata_o   (ram_wdata),
    .ram_raddr_o   (ram_raddr),
    .ram_rdata_i   (ram_rdata)
  );

  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_push();
    return wr_valid && (q.size() < DEPTH) && !flush && !rst;
  endfunction

  function automatic bit m_pop();
    return rd_ready && (q.size() > 0) && !flush && !rst;
  endfunction

  always @(posedge clk) begin
    automatic bit      pu = m_push();
    automatic bit      po = m_pop();
    automatic logic [DW-1:0] d = wr_data;
    if (rst || flush) begin
      q.delete();
      wr_total = 0;
    end else begin
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back(d);
        wr_total++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 64'(count), 64'(q.size()));
      check("wr_ready", 64'(wr_ready), 64'(q.size() < DEPTH));
      check("rd_valid", 64'(rd_valid), 64'(q.size() > 0));
      check("almost_full", 64'(almost_full), 64'(q.size() >= AFULL));
      check("ram_we", 64'(ram_we), 64'(m_push()));
      check("ram_waddr", 64'(ram_waddr), 64'(wr_total % DEPTH));
      check("ram_raddr", 64'(ram_raddr), 64'((wr_total - q.size()) % DEPTH));
      if (q.size() > 0) check("rd_data", 64'(rd_data), 64'(q[0]));
    end
  end

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;
    step(0, 0, 0, 0);

    // 1: reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);
    check("rst_addrs", 64'({ram_waddr, ram_raddr}), 64'd0);

    // 2: single word latency
    step(1, 32'hA5A5_0001, 0, 0);
    check("lat_valid", 64'(rd_valid), 64'd1);
    check("lat_data", 64'(rd_data), 64'hA5A5_0001);
    step(0, 0, 1, 0);
    check("lat_empty", 64'(rd_valid), 64'd0);
    step(0, 0, 0, 0);

    // 3: fill to full, overflow attempt, ordered drain
    for (int i = 1; i <= 8; i++) begin
      step(1, 32'(i), 0, 0);
      if (i == 5) check("afull_at5", 64'(almost_full), 64'd0);
      if (i == 6) check("afull_at6", 64'(almost_full), 64'd1);
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(wr_ready), 64'd0);
    step(1, 32'd9, 0, 0);
    check("ovf_count", 64'(count), 64'd8);
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", 64'(rd_data), 64'(i));
      step(0, 0, 1, 0);
    end
    check("drain_empty", 64'(count), 64'd0);

    // 4: full with continuous push+pop across several wraps
    for (int i = 0; i < 8; i++) step(1, 32'(100 + i), 0, 0);
    step(1, 32'd200, 1, 0);
    check("fullpp_count", 64'(count), 64'd7);
    check("fullpp_head", 64'(rd_data), 64'd101);
    for (int i = 1; i < 20; i++) step(1, 32'(200 + i), 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    check("wrap_drained", 64'(count), 64'd0);

    // 5: steady push+pop at count 4
    for (int i = 0; i < 4; i++) step(1, 32'(300 + i), 0, 0);
    for (int i = 0; i < 10; i++) step(1, 32'(400 + i), 1, 0);
    check("steady_count", 64'(count), 64'd4);
    check("steady_head", 64'(rd_data), 64'd406);

    // 6: flush then reset at count 5 with a pending write
    step(1, 32'd500, 0, 0);
    wr_valid = 1'b1; wr_data = 32'hDEAD_0001; flush = 1'b1;
    #1;
    check("flush_no_we", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(rd_valid), 64'd0);
    for (int i = 0; i < 5; i++) step(1, 32'(600 + i), 0, 0);
    check("refill_count", 64'(count), 64'd5);
    wr_valid = 1'b1; wr_data = 32'hDEAD_0002; flush = 1'b0; rst = 1'b1;
    #1;
    check("rst_no_we", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_count", 64'(count), 64'd0);
    check("rstmid_valid", 64'(rd_valid), 64'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
